// File: rtl/discus_snoop_pkg.sv
// Shared opcodes, FSM state encoding and defaults for the discus snoop host.
package discus_snoop_pkg;

  localparam logic [7:0] OP_WRM  = 8'h01;
  localparam logic [7:0] OP_WRP  = 8'h02;
  localparam logic [7:0] OP_RDM  = 8'h03;
  localparam logic [7:0] OP_BWRP = 8'h04;
  localparam logic [7:0] OP_BRDM = 8'h05;

  localparam logic [7:0]  ERR_BYTE_DEFAULT = 8'hEE;
  localparam int unsigned TIMEOUT_DEFAULT  = 65535;

  typedef enum logic [3:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_CNT,
    S_GET_DATA,
    S_WR_PULSE,
    S_RD_WAIT,
    S_RD_CAP,
    S_SEND,
    S_ERR
  } state_t;

  function automatic logic known_op(input logic [7:0] op);
    return (op >= OP_WRM) && (op <= OP_BRDM);
  endfunction

endpackage

// File: rtl/discus_snoop_timeout.sv
// Inter-byte watchdog: reloads on load, counts down while dec, flags expiry on the last idle cycle.
module discus_snoop_timeout #(
  parameter int unsigned CYCLES = 65535
)(
  input  logic snoop_clk,
  input  logic snoop_rst_n,
  input  logic load,
  input  logic dec,
  output logic expire
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES + 1) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(CYCLES);
  localparam logic [W-1:0] ONE      = W'(1);

  logic [W-1:0] cnt;

  always_ff @(posedge snoop_clk or negedge snoop_rst_n) begin
    if (!snoop_rst_n) begin
      cnt <= LOAD_VAL;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - ONE;
    end
  end

  // CYCLES == 0 disables the watchdog entirely.
  assign expire = (CYCLES != 0) && dec && (cnt == ONE);

endmodule

// File: rtl/discus_snoop_host.sv
// Byte-stream command host driving the discus snoop port (data/program memory access).
// Optional DISCUS_SNOOP_HOST_CSUM_EN adds an XOR checksum reply to burst ops 04/05.
module discus_snoop_host
  import discus_snoop_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter logic [7:0]  ERR_BYTE       = ERR_BYTE_DEFAULT
)(
  input  logic       snoop_clk,
  input  logic       snoop_rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] snoopa,
  output logic [7:0] snoopd,
  output logic       snoopm,
  output logic       snoopp,
  input  logic [7:0] snoopq,
  output logic       busy
);

  // Handshake: a byte moves on an edge where valid && ready; valid/data hold until then.
  state_t     state, next;
  logic [7:0] op;
  logic [8:0] cnt;
  logic       alive;
  logic       rx_fire, tx_fire, in_get, last, expire;

`ifdef DISCUS_SNOOP_HOST_CSUM_EN
  logic [7:0] acc;
  logic       csum_phase;
`else
  localparam logic csum_phase = 1'b0;
`endif

  assign in_get   = (state == S_GET_ADDR) || (state == S_GET_CNT) || (state == S_GET_DATA);
  assign rx_ready = alive && ((state == S_IDLE) || in_get);
  assign tx_valid = (state == S_SEND);
  assign rx_fire  = rx_valid && rx_ready;
  assign tx_fire  = tx_valid && tx_ready;
  assign last     = (cnt == 9'd1);
  assign busy     = (state != S_IDLE);
  // Strobes decode straight from state so an async reset removes them at once.
  assign snoopm   = (state == S_WR_PULSE) && (op == OP_WRM);
  assign snoopp   = (state == S_WR_PULSE) && (op != OP_WRM);

  discus_snoop_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .snoop_clk   (snoop_clk),
    .snoop_rst_n (snoop_rst_n),
    .load        (!in_get || rx_fire),
    .dec         (in_get && !rx_valid),
    .expire      (expire)
  );

  always_ff @(posedge snoop_clk or negedge snoop_rst_n) begin
    if (!snoop_rst_n) state <= S_IDLE;
    else              state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      S_IDLE:     if (rx_fire) next = known_op(rx_data) ? S_GET_ADDR : S_ERR;
      S_GET_ADDR: if (expire) next = S_IDLE;
                  else if (rx_fire) begin
                    if ((op == OP_BWRP) || (op == OP_BRDM)) next = S_GET_CNT;
                    else if (op == OP_RDM)                  next = S_RD_WAIT;
                    else                                    next = S_GET_DATA;
                  end
      S_GET_CNT:  if (expire) next = S_IDLE;
                  else if (rx_fire) next = (op == OP_BRDM) ? S_RD_WAIT : S_GET_DATA;
      S_GET_DATA: if (expire) next = S_IDLE;
                  else if (rx_fire) next = S_WR_PULSE;
      S_WR_PULSE: begin
        if (!last) next = S_GET_DATA;
`ifdef DISCUS_SNOOP_HOST_CSUM_EN
        else if (op == OP_BWRP) next = S_SEND;
`endif
        else next = S_IDLE;
      end
      S_RD_WAIT:  next = S_RD_CAP;
      S_RD_CAP:   next = S_SEND;
      S_ERR:      next = S_SEND;
      S_SEND: if (tx_fire) begin
        if (!csum_phase && (op == OP_BRDM) && !last) next = S_RD_WAIT;
`ifdef DISCUS_SNOOP_HOST_CSUM_EN
        else if (!csum_phase && (op == OP_BRDM)) next = S_SEND;
`endif
        else next = S_IDLE;
      end
      default:    next = S_IDLE;
    endcase
  end

  always_ff @(posedge snoop_clk or negedge snoop_rst_n) begin
    if (!snoop_rst_n) begin
      alive   <= 1'b0;
      op      <= 8'd0;
      cnt     <= 9'd0;
      snoopa  <= 8'd0;
      snoopd  <= 8'd0;
      tx_data <= 8'd0;
`ifdef DISCUS_SNOOP_HOST_CSUM_EN
      acc        <= 8'd0;
      csum_phase <= 1'b0;
`endif
    end else begin
      alive <= 1'b1;
      case (state)
        S_IDLE: if (rx_fire) begin
          op <= rx_data;
`ifdef DISCUS_SNOOP_HOST_CSUM_EN
          acc        <= 8'd0;
          csum_phase <= 1'b0;
`endif
        end
        S_GET_ADDR: if (rx_fire) begin
          snoopa <= rx_data;
          cnt    <= 9'd1;
        end
        S_GET_CNT: if (rx_fire) cnt <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
        S_GET_DATA: if (rx_fire) begin
          snoopd <= rx_data;
`ifdef DISCUS_SNOOP_HOST_CSUM_EN
          acc <= acc ^ rx_data;
`endif
        end
        S_WR_PULSE: begin
          cnt <= cnt - 9'd1;
          if (op == OP_BWRP) snoopa <= snoopa + 8'd1;
`ifdef DISCUS_SNOOP_HOST_CSUM_EN
          if (last && (op == OP_BWRP)) tx_data <= acc;
`endif
        end
        S_RD_CAP: tx_data <= snoopq;
        S_ERR:    tx_data <= ERR_BYTE;
        S_SEND: if (tx_fire && !csum_phase) begin
          cnt <= cnt - 9'd1;
          if (op == OP_BRDM) snoopa <= snoopa + 8'd1;
`ifdef DISCUS_SNOOP_HOST_CSUM_EN
          acc <= acc ^ tx_data;
          // Checksum byte follows the last burst byte and covers it too.
          if ((op == OP_BRDM) && last) begin
            tx_data    <= acc ^ tx_data;
            csum_phase <= 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_discus_snoop_host.sv
// Bench for discus_snoop_host: directed scenarios plus random commands against a memory/queue model.
module tb_discus_snoop_host;

  localparam int TO = 16;

  logic       snoop_clk = 1'b0;
  logic       snoop_rst_n = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] snoopa, snoopd, snoopq;
  logic       snoopm, snoopp, busy;

  always #5 snoop_clk = ~snoop_clk;

  discus_snoop_host #(.TIMEOUT_CYCLES(TO), .ERR_BYTE(8'hEE)) dut (
    .snoop_clk   (snoop_clk),
    .snoop_rst_n (snoop_rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .snoopa      (snoopa),
    .snoopd      (snoopd),
    .snoopm      (snoopm),
    .snoopp      (snoopp),
    .snoopq      (snoopq),
    .busy        (busy)
  );

  // Reference model: intended data memory contents, expected replies and expected write strobes.
  logic [7:0]  ref_mem [256];
  logic [7:0]  tgt_mem [256];
  logic [7:0]  exp_q [$];
  logic [16:0] wr_q [$];
  int tests_run = 0;
  int tests_failed = 0;
  int rdy_mode = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Target data memory: registered read, written on snoopm.
  always @(posedge snoop_clk) begin
    snoopq <= tgt_mem[snoopa];
    if (snoopm) tgt_mem[snoopa] <= snoopd;
  end

  initial forever begin
    @(posedge snoop_clk);
    #1;
    case (rdy_mode)
      0:       tx_ready = ($urandom_range(0, 3) != 0);
      1:       tx_ready = 1'b0;
      default: tx_ready = 1'b1;
    endcase
  end

  logic        prev_stb = 1'b0;
  logic        prev_hold = 1'b0;
  logic [7:0]  prev_txd = 8'd0;
  logic [16:0] w;

  always @(negedge snoop_clk) begin
    if (!snoop_rst_n) begin
      prev_stb  = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (snoopm || snoopp) begin
        check("strobe_exclusive", {31'd0, snoopm && snoopp}, 32'd0);
        check("strobe_one_cycle", {31'd0, prev_stb}, 32'd0);
        check("strobe_expected", {31'd0, wr_q.size() != 0}, 32'd1);
        if (wr_q.size() != 0) begin
          w = wr_q.pop_front();
          check("wr_addr", snoopa, w[15:8]);
          check("wr_data", snoopd, w[7:0]);
          check("wr_prog", snoopp, w[16]);
        end
      end
      prev_stb = snoopm || snoopp;
      if (prev_hold) begin
        check("tx_hold_valid", tx_valid, 1);
        check("tx_hold_data", tx_data, prev_txd);
      end
      if (tx_valid && tx_ready) begin
        check("reply_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) check("reply_data", tx_data, exp_q.pop_front());
      end
      prev_hold = tx_valid && !tx_ready;
      prev_txd  = tx_data;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    @(negedge snoop_clk);
    while (!rx_ready && n < 500) begin
      @(negedge snoop_clk);
      n++;
    end
    if (n >= 500) check("rx_accept_timeout", n, 0);
    @(posedge snoop_clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic gap();
    int g;
    g = $urandom_range(0, 3);
    if (g > 0) begin
      repeat (g) @(posedge snoop_clk);
      #1;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0 || wr_q.size() != 0) && n < 3000) begin
      @(negedge snoop_clk);
      n++;
    end
    check("cmd_done_in_time", {31'd0, n < 3000}, 32'd1);
    @(posedge snoop_clk);
    #1;
  endtask

  task automatic cmd_write(input logic prog, input logic [7:0] a, input logic [7:0] d);
    wr_q.push_back({prog, a, d});
    if (!prog) ref_mem[a] = d;
    send_byte(prog ? 8'h02 : 8'h01); gap();
    send_byte(a); gap();
    send_byte(d);
    wait_done();
  endtask

  task automatic cmd_read(input logic [7:0] a);
    exp_q.push_back(ref_mem[a]);
    send_byte(8'h03); gap();
    send_byte(a);
    wait_done();
  endtask

  task automatic cmd_bwrite(input logic [7:0] a, input logic [7:0] nb, input logic [7:0] d0);
    int n;
    logic [7:0] x, d, ai;
    n = (nb == 8'd0) ? 256 : int'(nb);
    x = 8'd0;
    send_byte(8'h04); gap();
    send_byte(a); gap();
    send_byte(nb);
    for (int i = 0; i < n; i++) begin
      d  = (d0 == 8'd0) ? 8'($urandom) : 8'(d0 * (i + 1));
      ai = a + 8'(i);
      wr_q.push_back({1'b1, ai, d});
      x = x ^ d;
      gap();
      send_byte(d);
    end
`ifdef DISCUS_SNOOP_HOST_CSUM_EN
    exp_q.push_back(x);
`endif
    wait_done();
  endtask

  task automatic cmd_bread(input logic [7:0] a, input logic [7:0] nb);
    int n;
    logic [7:0] x, ai;
    n = (nb == 8'd0) ? 256 : int'(nb);
    x = 8'd0;
    for (int i = 0; i < n; i++) begin
      ai = a + 8'(i);
      exp_q.push_back(ref_mem[ai]);
      x = x ^ ref_mem[ai];
    end
`ifdef DISCUS_SNOOP_HOST_CSUM_EN
    exp_q.push_back(x);
`endif
    send_byte(8'h05); gap();
    send_byte(a); gap();
    send_byte(nb);
    wait_done();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'(i);
      tgt_mem[i] = 8'(i);
    end

    // Reset state
    #12;
    check("rst_rx_ready", rx_ready, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_snoopa", snoopa, 0);
    check("rst_snoopd", snoopd, 0);
    check("rst_strobes", {snoopm, snoopp}, 0);
    check("rst_busy", busy, 0);
    @(posedge snoop_clk); #1;
    snoop_rst_n = 1'b1;
    @(posedge snoop_clk); #1;
    check("idle_rx_ready", rx_ready, 1);

    // Single data write, then read it back with latency and hold checks
    cmd_write(1'b0, 8'h10, 8'h5A);
    rdy_mode = 1;
    tx_ready = 1'b0;
    exp_q.push_back(ref_mem[8'h10]);
    send_byte(8'h03);
    send_byte(8'h10);
    @(negedge snoop_clk); check("rd_lat_c1", tx_valid, 0);
    @(negedge snoop_clk); check("rd_lat_c2", tx_valid, 0);
    @(negedge snoop_clk); check("rd_lat_c3", tx_valid, 1);
    check("rd_lat_data", tx_data, 8'h5A);
    repeat (5) @(negedge snoop_clk);
    check("rd_held_valid", tx_valid, 1);
    check("rd_held_data", tx_data, 8'h5A);
    rdy_mode = 2;
    wait_done();
    rdy_mode = 0;

    // Burst program write across the address wrap (data 11,22,33)
    cmd_bwrite(8'hFE, 8'h03, 8'h11);

    // 256-byte burst read from F0 wrapping to EF
    cmd_bread(8'hF0, 8'h00);

    // Unknown opcode, then a normal write and read
    exp_q.push_back(8'hEE);
    send_byte(8'h7F);
    wait_done();
    cmd_write(1'b0, 8'h00, 8'h00);
    cmd_read(8'h00);

    // Inter-byte timeout aborts silently after TO idle cycles
    send_byte(8'h01);
    send_byte(8'h20);
    repeat (TO) @(negedge snoop_clk);
    check("to_busy_before", busy, 1);
    @(negedge snoop_clk);
    check("to_busy_after", busy, 0);
    @(posedge snoop_clk); #1;
    cmd_read(8'h20);

    // Random command mix
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 5))
        0: begin
          exp_q.push_back(8'hEE);
          send_byte(8'($urandom_range(6, 255)));
          wait_done();
        end
        1: cmd_write(1'b0, 8'($urandom), 8'($urandom));
        2: cmd_write(1'b1, 8'($urandom), 8'($urandom));
        3: cmd_read(8'($urandom));
        4: cmd_bwrite(8'($urandom), 8'($urandom_range(1, 6)), 8'd0);
        default: cmd_bread(8'($urandom), 8'($urandom_range(1, 6)));
      endcase
    end

    // Reset during WR_PULSE discards the write
    send_byte(8'h01);
    send_byte(8'h30);
    send_byte(8'h77);
    check("pulse_before_reset", snoopm, 1);
    snoop_rst_n = 1'b0;
    #1;
    check("reset_drops_snoopm", snoopm, 0);
    check("reset_drops_busy", busy, 0);
    @(posedge snoop_clk); #1;
    snoop_rst_n = 1'b1;
    @(posedge snoop_clk); #1;
    cmd_read(8'h30);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
